// File: rtl/uart_pkg.sv
// Shared UART frame layout and transmit FSM encoding.
// The frame layout constants are also used by uart_rx.
package uart_pkg;

  localparam int START_IDX = 0;
  localparam int DATA_BITS = 8;
  localparam int STOP_IDX  = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serializer: N clocks per bit, LSB first, registered line output.
// A start pulse in IDLE latches the byte; done pulses in the last stop clock.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       uart_tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CLK_LAST = CW'(N - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_clk_q, cnt_clk_d;
  logic [3:0]    cnt_bit_q, cnt_bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;
  logic          wrap;

  assign wrap      = (cnt_clk_q == CLK_LAST);
  assign uart_tx_o = tx_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == STOP) && (cnt_bit_q == 4'(STOP_IDX)) && wrap;

  // tx_d is the line value for the following clock, so the line is a clean flop output
  always_comb begin
    state_d   = state_q;
    cnt_clk_d = cnt_clk_q;
    cnt_bit_d = cnt_bit_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    if (state_q != IDLE) begin
      cnt_clk_d = wrap ? '0 : cnt_clk_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        cnt_clk_d = '0;
        cnt_bit_d = 4'(START_IDX);
        tx_d      = 1'b1;
        if (start_i) begin
          state_d = START;
          shreg_d = data_i;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (wrap) begin
          state_d   = DATA;
          cnt_bit_d = cnt_bit_q + 4'd1;
          tx_d      = shreg_q[0];
        end
      end
      DATA: begin
        if (wrap) begin
          cnt_bit_d = cnt_bit_q + 4'd1;
          if (cnt_bit_q == 4'(DATA_BITS)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            tx_d    = shreg_q[1];
            shreg_d = {1'b0, shreg_q[7:1]};
          end
        end
      end
      STOP: begin
        if (wrap) begin
          state_d   = IDLE;
          cnt_bit_d = 4'(START_IDX);
          tx_d      = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_clk_q <= '0;
      cnt_bit_q <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_clk_q <= cnt_clk_d;
      cnt_bit_q <= cnt_bit_d;
      tx_q      <= tx_d;
    end
    shreg_q <= shreg_d;
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one 8N1 transmit line among REQ_NUM byte requesters.
// Grants are issued only while the serializer is idle; one-cycle req_rdy accepts the byte.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N       = 8,
  parameter int REQ_NUM = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REQ_NUM-1:0]         req_vld,
  input  logic [8*REQ_NUM-1:0]       req_data,
  output logic [REQ_NUM-1:0]         req_rdy,
  output logic                       uart_tx,
  output logic                       busy,
  output logic [$clog2(REQ_NUM)-1:0] gnt_id,
  output logic                       tx_done
);

  localparam int IDW = $clog2(REQ_NUM);

  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic [IDW-1:0] sel;
  logic           found;
  logic           start;
  logic [7:0]     sel_data;
  int             idx;

  // Search starts just after the last winner, so every requester waits at most REQ_NUM-1 frames
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int o = 1; o <= REQ_NUM; o++) begin
      idx = (int'(last_q) + o) % REQ_NUM;
      if (!found && req_vld[IDW'(idx)]) begin
        found = 1'b1;
        sel   = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_rdy  = '0;
    start    = 1'b0;
    last_d   = last_q;
    gnt_d    = gnt_q;
    sel_data = req_data[8*int'(sel) +: 8];
    if (!busy && !rst && found) begin
      req_rdy[sel] = 1'b1;
      start        = 1'b1;
      last_d       = sel;
      gnt_d        = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= IDW'(REQ_NUM - 1);
      gnt_q  <= '0;
    end else begin
      last_q <= last_d;
      gnt_q  <= gnt_d;
    end
  end

  assign gnt_id = gnt_q;

  uart_tx_core #(
    .N(N)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .data_i   (sel_data),
    .uart_tx_o(uart_tx),
    .busy_o   (busy),
    .done_o   (tx_done)
  );

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus random requests against a frame-timing model.
module tb_uart_tx_arb;

  localparam int N  = 8;
  localparam int RN = 4;
  localparam int FR = 10 * N;

  logic            clk = 1'b0;
  logic            rst;
  logic [RN-1:0]   req_vld;
  logic [8*RN-1:0] req_data;
  logic [RN-1:0]   req_rdy;
  logic            uart_tx;
  logic            busy;
  logic [1:0]      gnt_id;
  logic            tx_done;

  always #5 clk = ~clk;

  uart_tx_arb #(.N(N), .REQ_NUM(RN)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_data(req_data),
    .req_rdy (req_rdy),
    .uart_tx (uart_tx),
    .busy    (busy),
    .gnt_id  (gnt_id),
    .tx_done (tx_done)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  bit auto_drop  = 1'b0;

  bit         m_active;
  int         m_k;
  logic [7:0] m_byte;
  int         m_gnt;
  int         m_last;
  logic [7:0] rxb;

  int acc_log[$];
  int acc_time[$];
  int done_time[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [RN-1:0] v);
    for (int o = 1; o <= RN; o++) begin
      if (v[(last + o) % RN]) return (last + o) % RN;
    end
    return -1;
  endfunction

  // One clock: check outputs against the model at mid-cycle, then advance past the next edge
  task automatic tick();
    int            pick;
    int            bitn;
    logic          exp_tx;
    logic [RN-1:0] obs_rdy;
    #1;
    obs_rdy = req_rdy;
    for (int i = 0; i < RN; i++) begin
      if (req_rdy[i]) begin
        acc_log.push_back(i);
        acc_time.push_back(cyc);
      end
    end
    if (tx_done === 1'b1) done_time.push_back(cyc);
    if (rst) begin
      chk("rdy_in_reset", 32'(req_rdy), 32'd0);
      m_active = 1'b0;
      m_last   = RN - 1;
      m_gnt    = 0;
    end else if (m_active) begin
      bitn   = (m_k - 1) / N;
      exp_tx = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : m_byte[bitn-1];
      chk("line", 32'(uart_tx), 32'(exp_tx));
      chk("busy", 32'(busy), 32'd1);
      chk("tx_done", 32'(tx_done), 32'(m_k == FR));
      chk("rdy_busy", 32'(req_rdy), 32'd0);
      chk("gnt_id", 32'(gnt_id), 32'(m_gnt));
      if (bitn >= 1 && bitn <= 8 && ((m_k - 1) % N) == N / 2) rxb[bitn-1] = uart_tx;
      if (m_k == FR) begin
        chk("rx_byte", 32'(rxb), 32'(m_byte));
        m_active = 1'b0;
      end else begin
        m_k++;
      end
    end else begin
      pick = rr_pick(m_last, req_vld);
      chk("idle_line", 32'(uart_tx), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(tx_done), 32'd0);
      chk("idle_gnt", 32'(gnt_id), 32'(m_gnt));
      chk("req_rdy", 32'(req_rdy), (pick >= 0) ? (32'd1 << pick) : 32'd0);
      if (pick >= 0) begin
        m_active = 1'b1;
        m_k      = 1;
        m_byte   = req_data[8*pick +: 8];
        m_gnt    = pick;
        m_last   = pick;
      end
    end
    @(negedge clk);
    cyc++;
    if (auto_drop) req_vld = req_vld & ~obs_rdy;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    ticks(n);
    rst = 1'b0;
    acc_log.delete();
    acc_time.delete();
    done_time.delete();
  endtask

  task automatic run_until_acc(input int n, input int lim);
    int t;
    t = 0;
    while (acc_log.size() < n && t < lim) begin
      tick();
      t++;
    end
    chk("accept_count", 32'(acc_log.size()), 32'(n));
  endtask

  initial begin
    rst      = 1'b1;
    req_vld  = '0;
    req_data = '0;
    @(negedge clk);

    // 1: single byte from requester 0
    do_reset(2);
    tick();
    auto_drop = 1'b1;
    req_data[7:0] = 8'hA5;
    req_vld = 4'b0001;
    run_until_acc(1, 20);
    ticks(FR + 5);
    chk("s1_grant", 32'(acc_log[0]), 32'd0);
    chk("s1_done_cnt", 32'(done_time.size()), 32'd1);
    if (done_time.size() == 1) chk("s1_latency", 32'(done_time[0] - acc_time[0]), 32'(FR));

    // 2: all four requesting at once
    do_reset(1);
    req_data = 32'h44332211;
    req_vld  = 4'b1111;
    run_until_acc(4, 4 * (FR + 1) + 10);
    ticks(FR + 5);
    for (int i = 0; i < 4 && i < acc_log.size(); i++) chk("s2_order", 32'(acc_log[i]), 32'(i));
    for (int i = 1; i < 4 && i < acc_time.size(); i++)
      chk("s2_spacing", 32'(acc_time[i] - acc_time[i-1]), 32'(FR + 1));

    // 3: two persistent requesters alternate
    do_reset(1);
    auto_drop = 1'b0;
    req_data  = 32'h00C35A00;
    req_vld   = 4'b0110;
    run_until_acc(4, 4 * (FR + 1) + 10);
    req_vld = '0;
    ticks(FR + 5);
    if (acc_log.size() >= 4) begin
      chk("s3_g0", 32'(acc_log[0]), 32'd1);
      chk("s3_g1", 32'(acc_log[1]), 32'd2);
      chk("s3_g2", 32'(acc_log[2]), 32'd1);
      chk("s3_g3", 32'(acc_log[3]), 32'd2);
    end

    // 4: reset during D3, then requesters 0 and 3
    do_reset(1);
    auto_drop = 1'b1;
    req_data  = 32'($urandom);
    req_vld   = 4'b0001;
    run_until_acc(1, 20);
    ticks(4 * N + 2);
    do_reset(1);
    #1;
    chk("s4_line_after_rst", 32'(uart_tx), 32'd1);
    chk("s4_busy_after_rst", 32'(busy), 32'd0);
    @(negedge clk);
    cyc++;
    req_data = 32'($urandom);
    req_vld  = 4'b1001;
    run_until_acc(2, 2 * (FR + 1) + 10);
    ticks(FR + 5);
    if (acc_log.size() >= 2) begin
      chk("s4_first", 32'(acc_log[0]), 32'd0);
      chk("s4_second", 32'(acc_log[1]), 32'd3);
    end
    chk("s4_done_cnt", 32'(done_time.size()), 32'd2);

    // 5: requester 2 withdraws while the line is busy
    do_reset(1);
    req_data = 32'($urandom);
    req_vld  = 4'b0001;
    run_until_acc(1, 20);
    ticks(10);
    req_vld[2] = 1'b1;
    ticks(20);
    req_vld[2] = 1'b0;
    ticks(FR + 20);
    chk("s5_no_grant", 32'(acc_log.size()), 32'd1);

    // 6: back-to-back frames from one requester
    do_reset(1);
    auto_drop = 1'b0;
    req_data  = 32'h000000FF;
    req_vld   = 4'b0001;
    run_until_acc(1, 20);
    req_data[7:0] = 8'h00;
    run_until_acc(2, FR + 10);
    req_vld = '0;
    ticks(FR + 5);
    if (acc_time.size() >= 2 && done_time.size() >= 1) begin
      chk("s6_done_to_acc", 32'(acc_time[1] - done_time[0]), 32'd1);
      chk("s6_acc_spacing", 32'(acc_time[1] - acc_time[0]), 32'(FR + 1));
    end

    // random requests, withdrawals and one reset
    do_reset(1);
    auto_drop = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < RN; i++) begin
        if (!req_vld[i] && $urandom_range(7) == 0) begin
          req_vld[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end else if (req_vld[i] && $urandom_range(63) == 0) begin
          req_vld[i] = 1'b0;
        end
      end
      if (c == 1500) do_reset(1);
      else tick();
    end
    req_vld = '0;
    ticks(FR + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
